// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial select encoding, degree/tap constants and
// the per-polynomial state mask used by the generator and its unroll network.
package prbs_pkg;

    localparam int LFSR_MAXW = 31;

    typedef enum logic [1:0] {
        PRBS7  = 2'd0,
        PRBS9  = 2'd1,
        PRBS15 = 2'd2,
        PRBS31 = 2'd3
    } mode_e;

    // Degree n and feedback tap t for x^n + x^t + 1
    localparam int DEG7  = 7;
    localparam int TAP7  = 6;
    localparam int DEG9  = 9;
    localparam int TAP9  = 5;
    localparam int DEG15 = 15;
    localparam int TAP15 = 14;
    localparam int DEG31 = 31;
    localparam int TAP31 = 28;

    function automatic logic [LFSR_MAXW-1:0] lfsr_mask(input mode_e m);
        logic [LFSR_MAXW-1:0] msk;
        case (m)
            PRBS7:   msk = 31'h0000_007F;
            PRBS9:   msk = 31'h0000_01FF;
            PRBS15:  msk = 31'h0000_7FFF;
            default: msk = 31'h7FFF_FFFF;
        endcase
        return msk;
    endfunction

endpackage

// File: rtl/prbs_advance.sv
// Combinational unroll of DATA_W LFSR steps: emits the raw pattern word (oldest bit
// in the MSB) and the state after the last step. No registers, no handshake.
module prbs_advance
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [LFSR_MAXW-1:0] i_state,
    input  mode_e                i_mode,
    output logic [LFSR_MAXW-1:0] o_next,
    output logic [DATA_W-1:0]    o_word
);

    always_comb begin
        logic [LFSR_MAXW-1:0] s;
        logic [DATA_W-1:0]    word;
        logic                 msb;
        logic                 fb;
        s    = i_state;
        word = '0;
        msb  = 1'b0;
        fb   = 1'b0;
        for (int k = 0; k < DATA_W; k++) begin
            case (i_mode)
                PRBS7:   begin msb = s[DEG7-1];  fb = s[DEG7-1]  ^ s[TAP7-1];  end
                PRBS9:   begin msb = s[DEG9-1];  fb = s[DEG9-1]  ^ s[TAP9-1];  end
                PRBS15:  begin msb = s[DEG15-1]; fb = s[DEG15-1] ^ s[TAP15-1]; end
                default: begin msb = s[DEG31-1]; fb = s[DEG31-1] ^ s[TAP31-1]; end
            endcase
            // Shifting left each step leaves the first-emitted bit in the word MSB
            word = word << 1;
            word[0] = msb;
            s = {s[LFSR_MAXW-2:0], fb} & lfsr_mask(i_mode);
        end
        o_next = s;
        o_word = word;
    end

endmodule

// File: rtl/prbs_gen.sv
// Multi-polynomial PRBS source on a valid/ready stream; first word valid one cycle after load/enable.
// Backpressure holds valid, data, state and counter until ready; load aborts the current word.
module prbs_gen
    import prbs_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           mode_i,
    input  logic [LFSR_MAXW-1:0] seed_i,
    input  logic                 load_i,
    input  logic                 en_i,
    input  logic                 ready_i,
    input  logic                 inj_err_i,
    output logic                 valid_o,
    output logic [DATA_W-1:0]    data_o,
    output logic [CNT_W-1:0]     word_cnt_o,
    output logic [LFSR_MAXW-1:0] state_o
);

    mode_e                r_mode;
    logic [LFSR_MAXW-1:0] r_state;
    logic                 r_valid;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err_pend;

    mode_e                w_mode_in;
    logic [LFSR_MAXW-1:0] w_seed_msk;
    logic [LFSR_MAXW-1:0] w_seed_state;
    logic [LFSR_MAXW-1:0] w_next;
    logic [DATA_W-1:0]    w_word;
    logic                 w_xfer;

    // A handshake in the load cycle is swallowed: the word is not consumed
    assign w_xfer       = r_valid & ready_i & ~load_i;
    assign w_mode_in    = mode_e'(mode_i);
    assign w_seed_msk   = seed_i & lfsr_mask(w_mode_in);
    assign w_seed_state = (w_seed_msk == '0) ? lfsr_mask(w_mode_in) : w_seed_msk;

    prbs_advance #(
        .DATA_W (DATA_W)
    ) u_advance (
        .i_state (r_state),
        .i_mode  (r_mode),
        .o_next  (w_next),
        .o_word  (w_word)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode     <= PRBS7;
            r_state    <= lfsr_mask(PRBS7);
            r_valid    <= 1'b0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
        end else begin
            r_err_pend <= inj_err_i | (r_err_pend & ~w_xfer);
            if (load_i) begin
                r_mode  <= w_mode_in;
                r_state <= w_seed_state;
                r_cnt   <= '0;
                r_valid <= 1'b0;
            end else begin
                if (w_xfer) begin
                    r_state <= w_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                if (!r_valid || ready_i) begin
                    r_valid <= en_i;
                end
            end
        end
    end

    assign valid_o    = r_valid;
    assign data_o     = w_word ^ DATA_W'(r_err_pend);
    assign word_cnt_o = r_cnt;
    assign state_o    = r_state;

endmodule

// File: tb/tb_prbs_gen.sv
// Bench for prbs_gen: directed vector table, hand sequences for error injection, period,
// counter wrap and async reset, then randomized traffic against a bit-sequence model.
module tb_prbs_gen;

    localparam int DW = 8;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [30:0] seed;
    logic        load, en, ready, inj;

    logic          valid;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
    logic [30:0]   state;

    logic        v1;
    logic [0:0]  d1;
    logic [7:0]  c1;
    logic [30:0] s1;

    always #5 clk = ~clk;

    prbs_gen #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .seed_i(seed), .load_i(load),
        .en_i(en), .ready_i(ready), .inj_err_i(inj), .valid_o(valid), .data_o(data),
        .word_cnt_o(cnt), .state_o(state)
    );

    prbs_gen #(.DATA_W(1), .CNT_W(8)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .seed_i(seed), .load_i(load),
        .en_i(en), .ready_i(ready), .inj_err_i(inj), .valid_o(v1), .data_o(d1),
        .word_cnt_o(c1), .state_o(s1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the output bit stream b[] obeys b[j+n] = b[j] ^ b[j+n-t]; mq[0] is the
    // oldest bit of the word currently presented, and the state is mq[0..n-1].
    int DEG[4] = '{7, 9, 15, 31};
    int TAP[4] = '{6, 5, 14, 28};
    int m_n, m_t, m_cnt;
    bit mq[$];
    bit m_v, m_err;

    function automatic void m_load(input int md, input logic [30:0] sd);
        longint unsigned msk, s;
        m_n = DEG[md];
        m_t = TAP[md];
        msk = (64'd1 << m_n) - 64'd1;
        s = {33'd0, sd} & msk;
        if (s == 0) s = msk;
        mq.delete();
        for (int k = 0; k < m_n; k++) mq.push_back(s[m_n-1-k]);
    endfunction

    function automatic void m_fill();
        while (mq.size() < m_n + DW) begin
            int i;
            i = mq.size();
            mq.push_back(mq[i-m_n] ^ mq[i-m_t]);
        end
    endfunction

    function automatic logic [DW-1:0] m_clean();
        logic [DW-1:0] w;
        m_fill();
        w = '0;
        for (int k = 0; k < DW; k++) w[DW-1-k] = mq[k];
        return w;
    endfunction

    function automatic logic [30:0] m_state();
        logic [30:0] s;
        s = '0;
        for (int k = 0; k < m_n; k++) s[m_n-1-k] = mq[k];
        return s;
    endfunction

    function automatic void m_reset();
        m_load(0, 31'h7F);
        m_v = 1'b0;
        m_err = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic void m_step(input bit ld, input bit [1:0] md, input bit [30:0] sd,
                                   input bit e, input bit r, input bit ij);
        bit x;
        x = m_v && r;
        if (ld) begin
            m_load(int'(md), sd);
            m_cnt = 0;
            m_v = 1'b0;
            m_err = m_err | ij;
        end else begin
            if (x) begin
                m_fill();
                mq = mq[DW:$];
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
            if (!m_v || r) m_v = e;
            m_err = ij | (m_err & !x);
        end
    endfunction

    task automatic check_model();
        chk("m_valid", 32'(valid), 32'(m_v));
        chk("m_data", 32'(data), 32'(m_clean() ^ DW'(m_err)));
        chk("m_cnt", 32'(cnt), 32'(m_cnt));
        chk("m_state", 32'(state), 32'(m_state()));
    endtask

    // Drive at a negedge, let one posedge happen, compare at the next negedge.
    task automatic step(input bit ld, input bit [1:0] md, input bit [30:0] sd,
                        input bit e, input bit r, input bit ij);
        load = ld; mode = md; seed = sd; en = e; ready = r; inj = ij;
        m_step(ld, md, sd, e, r, ij);
        @(negedge clk);
        load = 1'b0;
        inj = 1'b0;
        check_model();
    endtask

    typedef struct packed {
        logic        ld;
        logic [1:0]  md;
        logic [30:0] sd;
        logic        en;
        logic        rdy;
        logic        inj;
        logic        ev;
        logic [7:0]  ed;
        logic [3:0]  ec;
        logic [30:0] es;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] w0, g;
        logic [30:0]   rs;
        int ret, rc;
        bit rl, rr, ri, re;

        tbl[0]  = '{1'b0, 2'd0, 31'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFE, 4'd0, 31'h7F};
        tbl[1]  = '{1'b0, 2'd0, 31'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 4'd1, 31'h02};
        tbl[2]  = '{1'b0, 2'd0, 31'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h18, 4'd2, 31'h0C};
        tbl[3]  = '{1'b0, 2'd0, 31'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h18, 4'd2, 31'h0C};
        tbl[4]  = '{1'b0, 2'd0, 31'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h18, 4'd2, 31'h0C};
        tbl[5]  = '{1'b0, 2'd0, 31'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h51, 4'd3, 31'h28};
        tbl[6]  = '{1'b1, 2'd2, 31'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 4'd0, 31'h7FFF};
        tbl[7]  = '{1'b0, 2'd0, 31'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 4'd0, 31'h7FFF};
        tbl[8]  = '{1'b0, 2'd0, 31'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFE, 4'd1, 31'h7F00};
        tbl[9]  = '{1'b1, 2'd0, 31'h85, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0A, 4'd0, 31'h05};
        tbl[10] = '{1'b0, 2'd3, 31'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0A, 4'd0, 31'h05};
        tbl[11] = '{1'b0, 2'd3, 31'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 4'd1, 31'h1E};

        rst_n = 1'b0;
        load = 1'b0; mode = 2'd0; seed = '0; en = 1'b0; ready = 1'b0; inj = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_data", 32'(data), 32'hFE);
        chk("rst_cnt", 32'(cnt), 32'h0);
        chk("rst_state", 32'(state), 32'h7F);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].ld, tbl[i].md, tbl[i].sd, tbl[i].en, tbl[i].rdy, tbl[i].inj);
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_data", i), 32'(data), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(tbl[i].ec));
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].es));
        end

        // Injection while stalled corrupts the held word; the following word is clean
        w0 = m_clean();
        step(1'b0, 2'd0, 31'h0, 1'b1, 1'b0, 1'b1);
        chk("inj_held_corrupt", 32'(data), 32'(w0 ^ 8'h01));
        step(1'b0, 2'd0, 31'h0, 1'b1, 1'b1, 1'b0);
        chk("inj_next_clean", 32'(data), 32'(m_clean()));

        // Injection coinciding with a transfer: current clean, next corrupted
        chk("injx_cur_clean", 32'(data), 32'(m_clean()));
        step(1'b0, 2'd0, 31'h0, 1'b1, 1'b1, 1'b1);
        g = m_clean();
        chk("injx_next_corrupt", 32'(data), 32'(g ^ 8'h01));
        step(1'b0, 2'd0, 31'h0, 1'b1, 1'b1, 1'b0);
        chk("injx_after_clean", 32'(data), 32'(m_clean()));

        // PRBS7 period on the 1-bit-wide instance
        step(1'b1, 2'd0, 31'h7F, 1'b1, 1'b1, 1'b0);
        step(1'b0, 2'd0, 31'h0, 1'b1, 1'b1, 1'b0);
        chk("p7_start_valid", 32'(v1), 32'h1);
        chk("p7_start_bit", 32'(d1), 32'h1);
        ret = -1;
        rc = -1;
        for (int i = 1; i <= 130; i++) begin
            step(1'b0, 2'd0, 31'h0, 1'b1, 1'b1, 1'b0);
            if (ret < 0 && s1 == 31'h7F) begin
                ret = i;
                rc = int'(c1);
            end
        end
        chk("p7_period", 32'(ret), 32'd127);
        chk("p7_cnt_at_period", 32'(rc), 32'd127);

        // PRBS9 word stream repeats after 511 words; 4-bit counter wraps 15 -> 0
        step(1'b1, 2'd1, 31'h1FF, 1'b1, 1'b1, 1'b0);
        step(1'b0, 2'd0, 31'h0, 1'b1, 1'b1, 1'b0);
        w0 = m_clean();
        for (int i = 1; i <= 511; i++) begin
            step(1'b0, 2'd0, 31'h0, 1'b1, 1'b1, 1'b0);
            if (i == 15) chk("cnt_15", 32'(cnt), 32'd15);
            if (i == 16) chk("cnt_wrap", 32'(cnt), 32'd0);
        end
        chk("p9_state_repeat", 32'(state), 32'h1FF);
        chk("p9_word_repeat", 32'(data), 32'(w0));

        // Reset mid-stream takes effect without a clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_state", 32'(state), 32'h7F);
        chk("arst_cnt", 32'(cnt), 32'h0);
        chk("arst_data", 32'(data), 32'hFE);
        chk("arst_state_w1", 32'(s1), 32'h7F);
        en = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();

        for (int i = 0; i < 1500; i++) begin
            rl = ($urandom_range(0, 39) == 0);
            re = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) != 0);
            ri = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 3) == 0) ? 31'h0 : 31'($urandom);
            step(rl, 2'($urandom_range(0, 3)), rs, re, rr, ri);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
